vga_timing_gen: RTL and testbench

Parametrised VGA/DVI timing generator. Successor to the fixed 11-bit sync generator.
Adds counter-width generics, a pixel clock-enable, frame-synchronous shadowing of runtime timing fields, zero-length field protection, and SOF/EOL strobes.
Sits between the pixel clock domain and the video pipeline: drives sync/active/coordinates to the pattern/overlay logic and PHY.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_axis_fsm.sv | 96 +++++++++
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types for the VGA/DVI timing generator.
// Axis state encoding and the packed shadow bundle for one axis.
package vga_timing_pkg;

    localparam int DEF_CW = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_BP,
        ST_ACTIVE,
        ST_FP
    } axis_state_e;

    typedef struct packed {
        logic [DEF_CW-1:0] sync;
        logic [DEF_CW-1:0] bp;
        logic [DEF_CW-1:0] active;
        logic [DEF_CW-1:0] fp;
    } timing_t;

endpackage

// File: rtl/vga_axis_fsm.sv
// One timing axis: state, down-counter, zero-length clamp,
// shadowed field lengths and the active-index counter.
module vga_axis_fsm
    import vga_timing_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          adv_i,
    input  logic          cap_i,
    input  timing_t       fld_i,
    input  logic          pol_i,
    output axis_state_e   st_d_o,
    output logic [CW-1:0] cnt_d_o,
    output logic [CW-1:0] idx_d_o,
    output logic          pol_d_o,
    output logic          sync_ent_o,
    output logic          line_end_o
);

    axis_state_e   st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] idx_q, idx_d;
    timing_t       shd_q, shd_d;
    logic          pol_q, pol_d;
    logic          cap, last;

    function automatic logic [CW-1:0] flen(axis_state_e s, timing_t t);
        logic [DEF_CW-1:0] v;
        case (s)
            ST_SYNC:   v = t.sync;
            ST_BP:     v = t.bp;
            ST_ACTIVE: v = t.active;
            default:   v = t.fp;
        endcase
        return (v == '0) ? CW'(1) : CW'(v);
    endfunction

    assign last       = (cnt_q <= CW'(1));
    assign cap        = cap_i | (adv_i & (st_q == ST_IDLE));
    assign sync_ent_o = adv_i & ((st_q == ST_IDLE) | ((st_q == ST_FP) & last));
    assign line_end_o = adv_i & (st_q == ST_FP) & last;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        shd_d = shd_q;
        pol_d = pol_q;
        if (adv_i) begin
            // Captured values apply to the length loaded on this same edge
            if (cap) begin
                shd_d = fld_i;
                pol_d = pol_i;
            end
            if (st_q == ST_IDLE || last) begin
                unique case (st_q)
                    ST_IDLE:   st_d = ST_SYNC;
                    ST_SYNC:   st_d = ST_BP;
                    ST_BP:     st_d = ST_ACTIVE;
                    ST_ACTIVE: st_d = ST_FP;
                    ST_FP:     st_d = ST_SYNC;
                    default:   st_d = ST_IDLE;
                endcase
                cnt_d = flen(st_d, shd_d);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            idx_d = (st_q == ST_ACTIVE && st_d == ST_ACTIVE)
                  ? idx_q + CW'(1) : '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q  <= ST_IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            shd_q <= '0;
            pol_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            shd_q <= shd_d;
            pol_q <= pol_d;
        end
    end

    assign st_d_o  = st_d;
    assign cnt_d_o = cnt_d;
    assign idx_d_o = idx_d;
    assign pol_d_o = pol_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA/DVI timing generator with CE, frame-synchronous shadows and strobes.
// Define VGA_TIMING_TESTPAT_EN to build the grid/ramp test pattern on GEN_RGB.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CW    = DEF_CW,
    parameter int RGB_W = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [CW-1:0]    H_SYNC,
    input  logic [CW-1:0]    H_BACK_PORCH,
    input  logic [CW-1:0]    H_ACTIVE,
    input  logic [CW-1:0]    H_FRONT_PORCH,
    input  logic [CW-1:0]    V_SYNC,
    input  logic [CW-1:0]    V_BACK_PORCH,
    input  logic [CW-1:0]    V_ACTIVE,
    input  logic [CW-1:0]    V_FRONT_PORCH,
    input  logic             H_SYNC_POL,
    input  logic             V_SYNC_POL,
    output logic             GEN_ACTIVE,
    output logic             GEN_HSYNC,
    output logic             GEN_VSYNC,
    output logic             GEN_HSYNCP,
    output logic             GEN_VSYNCP,
    output logic [CW-1:0]    GEN_HCNT,
    output logic [CW-1:0]    GEN_VCNT,
    output logic             GEN_SOF,
    output logic             GEN_EOL,
    output logic [RGB_W-1:0] GEN_RGB
);

    timing_t       h_fld, v_fld;
    axis_state_e   h_st, v_st;
    logic [CW-1:0] h_cnt, v_cnt, h_idx, v_idx;
    logic          h_pol, v_pol, h_ent, v_ent, h_lend, v_lend;
    logic          unused_ok;

    assign h_fld = '{sync: DEF_CW'(H_SYNC), bp: DEF_CW'(H_BACK_PORCH),
                     active: DEF_CW'(H_ACTIVE), fp: DEF_CW'(H_FRONT_PORCH)};
    assign v_fld = '{sync: DEF_CW'(V_SYNC), bp: DEF_CW'(V_BACK_PORCH),
                     active: DEF_CW'(V_ACTIVE), fp: DEF_CW'(V_FRONT_PORCH)};

    vga_axis_fsm #(.CW(CW)) u_h (
        .CLK(CLK), .RST(RST), .adv_i(CE), .cap_i(v_ent),
        .fld_i(h_fld), .pol_i(H_SYNC_POL),
        .st_d_o(h_st), .cnt_d_o(h_cnt), .idx_d_o(h_idx), .pol_d_o(h_pol),
        .sync_ent_o(h_ent), .line_end_o(h_lend)
    );

    vga_axis_fsm #(.CW(CW)) u_v (
        .CLK(CLK), .RST(RST), .adv_i(CE & h_lend), .cap_i(v_ent),
        .fld_i(v_fld), .pol_i(V_SYNC_POL),
        .st_d_o(v_st), .cnt_d_o(v_cnt), .idx_d_o(v_idx), .pol_d_o(v_pol),
        .sync_ent_o(v_ent), .line_end_o(v_lend)
    );

    assign unused_ok = ^{h_ent, v_lend, v_cnt};

    logic          act_d, hs_d, vs_d, hsp_d, vsp_d, sof_d, eol_d;
    logic          act_q, hs_q, vs_q, hsp_q, vsp_q, sof_q, eol_q;
    logic [CW-1:0] hcnt_q, vcnt_q;

    // Outputs register the axes' next state so they move with the FSMs
    assign act_d = (h_st == ST_ACTIVE) & (v_st == ST_ACTIVE);
    assign hs_d  = (h_st == ST_SYNC);
    assign vs_d  = (v_st == ST_SYNC);
    assign hsp_d = (h_st != ST_IDLE) & (hs_d ~^ h_pol);
    assign vsp_d = (v_st != ST_IDLE) & (vs_d ~^ v_pol);
    assign sof_d = act_d & (h_idx == '0) & (v_idx == '0);
    assign eol_d = act_d & (h_cnt == CW'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            act_q  <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            hsp_q  <= 1'b0;
            vsp_q  <= 1'b0;
            sof_q  <= 1'b0;
            eol_q  <= 1'b0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (CE) begin
            act_q  <= act_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            hsp_q  <= hsp_d;
            vsp_q  <= vsp_d;
            sof_q  <= sof_d;
            eol_q  <= eol_d;
            hcnt_q <= h_idx;
            vcnt_q <= v_idx;
        end
    end

    assign GEN_ACTIVE = act_q;
    assign GEN_HSYNC  = hs_q;
    assign GEN_VSYNC  = vs_q;
    assign GEN_HSYNCP = hsp_q;
    assign GEN_VSYNCP = vsp_q;
    assign GEN_SOF    = sof_q;
    assign GEN_EOL    = eol_q;
    assign GEN_HCNT   = hcnt_q;
    assign GEN_VCNT   = vcnt_q;

`ifdef VGA_TIMING_TESTPAT_EN
    localparam int S = RGB_W / 3;
    logic [S-1:0]     ramp;
    logic [RGB_W-1:0] rgb_d, rgb_q;

    assign ramp = S'({h_idx[7:0], {S{1'b0}}} >> 8);

    always_comb begin
        rgb_d = '0;
        if (act_d) begin
            if (h_idx[3:0] == 4'd0 || v_idx[3:0] == 4'd0) begin
                rgb_d = '1;
            end else begin
                unique case (v_idx[5:4])
                    2'd0:    rgb_d = RGB_W'({ramp, ramp, ramp});
                    2'd1:    rgb_d = RGB_W'({ramp, {2*S{1'b0}}});
                    2'd2:    rgb_d = RGB_W'({{S{1'b0}}, ramp, {S{1'b0}}});
                    default: rgb_d = RGB_W'({{2*S{1'b0}}, ramp});
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) rgb_q <= '0;
        else if (CE) rgb_q <= rgb_d;
    end

    assign GEN_RGB = rgb_q;
`else
    assign GEN_RGB = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen against a position-based
// raster model (pixel/line positions and field sums).
module tb_vga_timing_gen;

    localparam int CW = 12;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          CE  = 1'b0;
    logic [CW-1:0] H_SYNC, H_BACK_PORCH, H_ACTIVE, H_FRONT_PORCH;
    logic [CW-1:0] V_SYNC, V_BACK_PORCH, V_ACTIVE, V_FRONT_PORCH;
    logic          H_SYNC_POL = 1'b1, V_SYNC_POL = 1'b1;
    logic          GEN_ACTIVE, GEN_HSYNC, GEN_VSYNC, GEN_HSYNCP, GEN_VSYNCP;
    logic [CW-1:0] GEN_HCNT, GEN_VCNT;
    logic          GEN_SOF, GEN_EOL;
    logic [23:0]   GEN_RGB;
    logic [54:0]   obs;

    vga_timing_gen #(.CW(CW), .RGB_W(24)) dut (
        .CLK(CLK), .RST(RST), .CE(CE),
        .H_SYNC(H_SYNC), .H_BACK_PORCH(H_BACK_PORCH),
        .H_ACTIVE(H_ACTIVE), .H_FRONT_PORCH(H_FRONT_PORCH),
        .V_SYNC(V_SYNC), .V_BACK_PORCH(V_BACK_PORCH),
        .V_ACTIVE(V_ACTIVE), .V_FRONT_PORCH(V_FRONT_PORCH),
        .H_SYNC_POL(H_SYNC_POL), .V_SYNC_POL(V_SYNC_POL),
        .GEN_ACTIVE(GEN_ACTIVE), .GEN_HSYNC(GEN_HSYNC), .GEN_VSYNC(GEN_VSYNC),
        .GEN_HSYNCP(GEN_HSYNCP), .GEN_VSYNCP(GEN_VSYNCP),
        .GEN_HCNT(GEN_HCNT), .GEN_VCNT(GEN_VCNT),
        .GEN_SOF(GEN_SOF), .GEN_EOL(GEN_EOL), .GEN_RGB(GEN_RGB)
    );

    always #5 CLK = ~CLK;

    assign obs = {GEN_ACTIVE, GEN_HSYNC, GEN_VSYNC, GEN_HSYNCP, GEN_VSYNCP,
                  GEN_HCNT, GEN_VCNT, GEN_SOF, GEN_EOL, GEN_RGB};

    int total = 0;
    int bad   = 0;

    // Model: position in line (hp), line in frame (ln, -1 = idle line)
    bit   m_on = 0;
    int   hp, ln;
    int   sh[8];
    logic mp_h, mp_v;

    function automatic int cl(int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic void m_cap();
        sh[0] = int'(H_SYNC);  sh[1] = int'(H_BACK_PORCH);
        sh[2] = int'(H_ACTIVE); sh[3] = int'(H_FRONT_PORCH);
        sh[4] = int'(V_SYNC);  sh[5] = int'(V_BACK_PORCH);
        sh[6] = int'(V_ACTIVE); sh[7] = int'(V_FRONT_PORCH);
        mp_h = H_SYNC_POL;
        mp_v = V_SYNC_POL;
    endfunction

    function automatic void m_adv();
        int lp, fl;
        if (!m_on) begin
            m_on = 1; m_cap(); hp = 0; ln = -1;
        end else begin
            lp = cl(sh[0]) + cl(sh[1]) + cl(sh[2]) + cl(sh[3]);
            fl = cl(sh[4]) + cl(sh[5]) + cl(sh[6]) + cl(sh[7]);
            hp++;
            if (hp >= lp) begin
                hp = 0;
                if (ln < 0 || ln >= fl - 1) begin
                    ln = 0; m_cap();
                end else begin
                    ln++;
                end
            end
        end
    endfunction

    function automatic logic [23:0] exp_rgb(logic act, int hc, int vc);
        logic [23:0] pat;
        logic        en;
        int          r;
        r = hc % 256;
        if (hc % 16 == 0 || vc % 16 == 0) pat = 24'hFFFFFF;
        else case ((vc / 16) % 4)
            0:       pat = 24'(r * 32'h010101);
            1:       pat = 24'(r << 16);
            2:       pat = 24'(r << 8);
            default: pat = 24'(r);
        endcase
`ifdef VGA_TIMING_TESTPAT_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return (en && act) ? pat : 24'h0;
    endfunction

    function automatic logic [54:0] m_exp();
        int   s, b, a, vs, vb, va, hc, vc;
        logic hsy, hac, vsy, vac, act, vsp;
        if (!m_on) return '0;
        s = cl(sh[0]); b = cl(sh[1]); a = cl(sh[2]);
        hsy = (hp < s);
        hac = (hp >= s + b) && (hp < s + b + a);
        hc  = hac ? hp - s - b : 0;
        vs = cl(sh[4]); vb = cl(sh[5]); va = cl(sh[6]);
        if (ln < 0) begin
            vsy = 0; vac = 0; vc = 0; vsp = 0;
        end else begin
            vsy = (ln < vs);
            vac = (ln >= vs + vb) && (ln < vs + vb + va);
            vc  = vac ? ln - vs - vb : 0;
            vsp = vsy ? mp_v : ~mp_v;
        end
        act = hac & vac;
        return {act, hsy, vsy, (hsy ? mp_h : ~mp_h), vsp, CW'(hc), CW'(vc),
                (act && hc == 0 && vc == 0), (act && hc == a - 1),
                exp_rgb(act, hc, vc)};
    endfunction

    task automatic tick(input bit ce);
        CE = ce;
        @(posedge CLK);
        if (ce) m_adv();
        #1;
    endtask

    task automatic set_h(input int a, input int b, input int c, input int d);
        H_SYNC = CW'(a); H_BACK_PORCH = CW'(b);
        H_ACTIVE = CW'(c); H_FRONT_PORCH = CW'(d);
    endtask

    task automatic set_v(input int a, input int b, input int c, input int d);
        V_SYNC = CW'(a); V_BACK_PORCH = CW'(b);
        V_ACTIVE = CW'(c); V_FRONT_PORCH = CW'(d);
    endtask

    task automatic do_reset();
        CE  = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST  = 1'b0;
        m_on = 0;
    endtask

    task automatic test_reset();
        logic [54:0] e;
        bit          hs_exp [3] = '{1'b1, 1'b1, 1'b0};
        set_h(2, 3, 8, 1); set_v(1, 1, 4, 1);
        H_SYNC_POL = 1'b1; V_SYNC_POL = 1'b1;
        #1 RST = 1'b1;
        #1;
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_async got=%h exp=0", obs);
        end
        CE = 1'b1;
        @(posedge CLK); #1;
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_held got=%h exp=0", obs);
        end
        RST = 1'b0; m_on = 0;
        for (int i = 0; i < 2; i++) begin
            tick(0);
            total++;
            if (obs !== '0) begin
                bad++; $display("FAIL reset_ce0 i=%0d got=%h exp=0", i, obs);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1); e = m_exp();
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL reset_start i=%0d got=%h exp=%h", i, obs, e);
            end
            total++;
            if (GEN_HSYNC !== hs_exp[i]) begin
                bad++; $display("FAIL reset_hsync i=%0d got=%b exp=%b",
                                i, GEN_HSYNC, hs_exp[i]);
            end
        end
    endtask

    task automatic test_basic();
        logic [54:0] e;
        int act_n = 0, sof_n = 0, eol_n = 0, eol_off = 0;
        int sof1 = -1, sof2 = -1;
        set_h(2, 3, 8, 1); set_v(1, 1, 4, 1);
        H_SYNC_POL = 1'($urandom); V_SYNC_POL = 1'($urandom);
        do_reset();
        for (int k = 1; k <= 14 + 2 * 98; k++) begin
            tick(1); e = m_exp();
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL basic k=%0d got=%h exp=%h", k, obs, e);
            end
            if (k >= 15 && k <= 112) begin
                act_n += int'(GEN_ACTIVE);
                sof_n += int'(GEN_SOF);
                if (GEN_EOL) begin
                    eol_n++;
                    if (GEN_HCNT != CW'(7)) eol_off++;
                end
            end
            if (GEN_SOF) begin
                if (sof1 < 0) sof1 = k;
                else if (sof2 < 0) sof2 = k;
            end
        end
        total++;
        if (act_n !== 32) begin bad++; $display("FAIL basic_active got=%0d exp=32", act_n); end
        total++;
        if (sof_n !== 1) begin bad++; $display("FAIL basic_sof got=%0d exp=1", sof_n); end
        total++;
        if (eol_n !== 4) begin bad++; $display("FAIL basic_eol got=%0d exp=4", eol_n); end
        total++;
        if (eol_off !== 0) begin bad++; $display("FAIL basic_eol_hcnt got=%0d exp=0", eol_off); end
        total++;
        if (sof2 - sof1 !== 98) begin
            bad++; $display("FAIL basic_frame got=%0d exp=98", sof2 - sof1);
        end
    endtask

    task automatic test_ce_toggle();
        logic [54:0] e;
        bit ce;
        int ce_n = 0, s1 = -1, s2 = -1;
        set_h(2, 3, 8, 1); set_v(1, 1, 4, 1);
        do_reset();
        for (int i = 0; i < 800 && s2 < 0; i++) begin
            ce = (i < 40) ? (i % 2 == 0) : ($urandom_range(3) != 0);
            tick(ce); e = m_exp();
            if (ce) ce_n++;
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL ce i=%0d ce=%0d got=%h exp=%h", i, ce, obs, e);
            end
            if (ce && GEN_SOF) begin
                if (s1 < 0) s1 = ce_n;
                else s2 = ce_n;
            end
        end
        total++;
        if (s2 < 0 || s2 - s1 !== 98) begin
            bad++; $display("FAIL ce_frame got=%0d exp=98", s2 - s1);
        end
    endtask

    task automatic test_midframe();
        logic [54:0] e;
        int a1 = 0, a2 = 0;
        set_h(2, 3, 8, 1); set_v(1, 1, 4, 1);
        do_reset();
        for (int k = 1; k <= 200; k++) begin
            tick(1); e = m_exp();
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL mid k=%0d got=%h exp=%h", k, obs, e);
            end
            if (k >= 15 && k <= 112) a1 += int'(GEN_ACTIVE);
            if (k >= 113 && k <= 189) a2 += int'(GEN_ACTIVE);
            if (k == 60) H_ACTIVE = CW'(5);
        end
        total++;
        if (a1 !== 32) begin bad++; $display("FAIL mid_old got=%0d exp=32", a1); end
        total++;
        if (a2 !== 20) begin bad++; $display("FAIL mid_new got=%0d exp=20", a2); end
    endtask

    task automatic test_zero_fields();
        logic [54:0] e;
        int s1 = -1, s2 = -1, hs_n = 0;
        set_h(2, 0, 8, 1); set_v(1, 1, 4, 0);
        do_reset();
        for (int k = 1; k <= 12 + 2 * 84 + 2; k++) begin
            tick(1); e = m_exp();
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL zero k=%0d got=%h exp=%h", k, obs, e);
            end
            if (k >= 13 && k <= 24) hs_n += int'(GEN_HSYNC);
            if (GEN_SOF) begin
                if (s1 < 0) s1 = k;
                else if (s2 < 0) s2 = k;
            end
        end
        total++;
        if (s2 - s1 !== 84) begin bad++; $display("FAIL zero_frame got=%0d exp=84", s2 - s1); end
        total++;
        if (hs_n !== 2) begin bad++; $display("FAIL zero_line_hsync got=%0d exp=2", hs_n); end
    endtask

    task automatic test_polarity_reset();
        logic [54:0] e;
        int lo_n = 0, hi_n = 0;
        set_h(2, 3, 8, 1); set_v(1, 1, 4, 1);
        H_SYNC_POL = 1'b0; V_SYNC_POL = 1'b1;
        do_reset();
        for (int k = 1; k <= 20 + 14; k++) begin
            tick(1); e = m_exp();
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL pol k=%0d got=%h exp=%h", k, obs, e);
            end
            if (k >= 15 && k <= 28) begin
                lo_n += int'(!GEN_HSYNCP);
                hi_n += int'(GEN_HSYNC);
            end
        end
        total++;
        if (lo_n !== 2) begin bad++; $display("FAIL pol_low got=%0d exp=2", lo_n); end
        total++;
        if (hi_n !== 2) begin bad++; $display("FAIL pol_raw got=%0d exp=2", hi_n); end
        #2 RST = 1'b1;
        #1;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL midline_rst got=%h exp=0", obs); end
        @(posedge CLK); #1;
        RST = 1'b0; m_on = 0;
        tick(1); e = m_exp();
        total++;
        if (obs !== e) begin bad++; $display("FAIL restart got=%h exp=%h", obs, e); end
    endtask

    task automatic test_pattern();
        logic [54:0] e;
        logic [23:0] w;
        logic [23:0] red;
        int hit_a = 0, hit_b = 0;
`ifdef VGA_TIMING_TESTPAT_EN
        w = 24'hFFFFFF; red = 24'h050000;
`else
        w = 24'h0; red = 24'h0;
`endif
        set_h(2, 3, 20, 1); set_v(1, 1, 20, 1);
        do_reset();
        for (int k = 1; k <= 26 + 23 * 26; k++) begin
            tick(1); e = m_exp();
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL pat k=%0d got=%h exp=%h", k, obs, e);
            end
            if (e[54] && e[49:38] == CW'(0) && e[37:26] == CW'(1)) begin
                hit_a++; total++;
                if (GEN_RGB !== w) begin bad++; $display("FAIL pat_grid got=%h exp=%h", GEN_RGB, w); end
            end
            if (e[54] && e[49:38] == CW'(5) && e[37:26] == CW'(17)) begin
                hit_b++; total++;
                if (GEN_RGB !== red) begin bad++; $display("FAIL pat_red got=%h exp=%h", GEN_RGB, red); end
            end
        end
        total++;
        if (hit_a !== 1 || hit_b !== 1) begin
            bad++; $display("FAIL pat_hits got=%0d/%0d exp=1/1", hit_a, hit_b);
        end
    endtask

    task automatic test_random();
        logic [54:0] e;
        bit ce;
        for (int it = 0; it < 4; it++) begin
            set_h($urandom_range(3), $urandom_range(3),
                  $urandom_range(6), $urandom_range(3));
            set_v($urandom_range(2), $urandom_range(2),
                  $urandom_range(4), $urandom_range(2));
            H_SYNC_POL = 1'($urandom); V_SYNC_POL = 1'($urandom);
            do_reset();
            for (int i = 0; i < 300; i++) begin
                ce = ($urandom_range(9) < 7);
                tick(ce); e = m_exp();
                total++;
                if (obs !== e) begin
                    bad++; $display("FAIL rand it=%0d i=%0d got=%h exp=%h", it, i, obs, e);
                end
                if (i == 150) begin
                    H_ACTIVE = CW'($urandom_range(1, 6));
                    V_SYNC = CW'($urandom_range(2));
                    H_SYNC_POL = 1'($urandom);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ce_toggle();
        test_midframe();
        test_zero_fields();
        test_polarity_reset();
        test_pattern();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
